// File: rtl/video_seq_pkg.sv
// rtl/video_seq_pkg.sv - state encoding shared by the video clock/reset sequencer
package video_seq_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] S_WAIT_MAIN = 3'd0;
   localparam logic [STATE_W-1:0] S_DIV_RST   = 3'd1;
   localparam logic [STATE_W-1:0] S_WAIT_SER  = 3'd2;
   localparam logic [STATE_W-1:0] S_TX_RST    = 3'd3;
   localparam logic [STATE_W-1:0] S_RUN       = 3'd4;
   localparam logic [STATE_W-1:0] S_FAULT     = 3'd5;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_MAIN = S_WAIT_MAIN,
      ST_DIV_RST   = S_DIV_RST,
      ST_WAIT_SER  = S_WAIT_SER,
      ST_TX_RST    = S_TX_RST,
      ST_RUN       = S_RUN,
      ST_FAULT     = S_FAULT
   } seq_state_e;

endpackage

// File: rtl/lock_sync.sv
// rtl/lock_sync.sv - two-flop synchronizer for a PLL lock flag, clears to 0 on reset
module lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/video_clk_rst_seq.sv
// rtl/video_clk_rst_seq.sv - HDMI pixel-path bring-up/recovery sequencer on the 27 MHz board clock
// Optional: VIDEO_SEQ_AUTO_RETRY_EN makes the fault state retry after a timeout period.
module video_clk_rst_seq
   import video_seq_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned DIV_RST_CYC      = 16,
   parameter int unsigned TX_RST_CYC       = 64,
   parameter int unsigned LOCK_TIMEOUT_CYC = 1000000,
   parameter int unsigned CNT_W            = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_lock,
   input  logic               ser_pll_lock,
   output logic               clkdiv_resetn,
   output logic               ser_pll_reset,
   output logic               tx_rst_n,
   output logic               disp_en,
   output logic               ready,
   output logic               fault,
   output logic [STATE_W-1:0] state_o,
   output logic [7:0]         lock_loss_cnt
);

   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] DIV_LAST     = CNT_W'(DIV_RST_CYC - 1);
   localparam logic [CNT_W-1:0] TX_LAST      = CNT_W'(TX_RST_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

   logic main_s;
   logic ser_s;

   lock_sync u_main_sync (.clk(clk), .rst(rst), .async_i(pll_lock),     .sync_o(main_s));
   lock_sync u_ser_sync  (.clk(clk), .rst(rst), .async_i(ser_pll_lock), .sync_o(ser_s));

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic [7:0]       loss_q, loss_d;
   logic             main_lost;
   logic             ser_lost;
   logic             wait_lock;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      tcnt_d    = '0;
      loss_d    = loss_q;
      wait_lock = (state_q == ST_WAIT_MAIN) ? main_s : ser_s;
      main_lost = !main_s && (state_q inside {ST_DIV_RST, ST_WAIT_SER, ST_TX_RST, ST_RUN});
      ser_lost  = !ser_s && (state_q inside {ST_TX_RST, ST_RUN});

      // Lock loss outranks any counter completing on the same edge; main loss outranks serial.
      if (main_lost || ser_lost) begin
         state_d = main_lost ? ST_WAIT_MAIN : ST_WAIT_SER;
         if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
         end
      end else begin
         case (state_q)
            ST_WAIT_MAIN, ST_WAIT_SER: begin
               tcnt_d = tcnt_q + CNT_W'(1);
               if (wait_lock && cnt_q == STABLE_LAST) begin
                  state_d = (state_q == ST_WAIT_MAIN) ? ST_DIV_RST : ST_TX_RST;
               end else if (tcnt_q == TIMEOUT_LAST) begin
                  state_d = ST_FAULT;
               end else if (!wait_lock) begin
                  cnt_d = '0;
               end
            end
            ST_DIV_RST: begin
               if (cnt_q == DIV_LAST) begin
                  state_d = ST_WAIT_SER;
               end
            end
            ST_TX_RST: begin
               if (cnt_q == TX_LAST) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               cnt_d = '0;
            end
            default: begin
`ifdef VIDEO_SEQ_AUTO_RETRY_EN
               if (cnt_q == TIMEOUT_LAST) begin
                  state_d = ST_WAIT_MAIN;
               end
`else
               cnt_d = '0;
`endif
            end
         endcase
      end

      if (state_d != state_q) begin
         cnt_d  = '0;
         tcnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_WAIT_MAIN;
         cnt_q         <= '0;
         tcnt_q        <= '0;
         loss_q        <= '0;
         clkdiv_resetn <= 1'b0;
         ser_pll_reset <= 1'b1;
         tx_rst_n      <= 1'b0;
         disp_en       <= 1'b0;
         ready         <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tcnt_q        <= tcnt_d;
         loss_q        <= loss_d;
         clkdiv_resetn <= (state_d inside {ST_WAIT_SER, ST_TX_RST, ST_RUN});
         ser_pll_reset <= !(state_d inside {ST_WAIT_SER, ST_TX_RST, ST_RUN});
         tx_rst_n      <= (state_d == ST_RUN);
         disp_en       <= (state_d == ST_RUN);
         ready         <= (state_d == ST_RUN);
         fault         <= (state_d == ST_FAULT);
      end
   end

   assign state_o       = state_q;
   assign lock_loss_cnt = loss_q;

endmodule
